// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operand type and operator
// codes (also decoded by the ALU), the ASCII characters the command parser
// recognises, the parser state encoding, and small character classifiers.
package calc_pkg;

  localparam logic [3:0] DTYPE_NONE = 4'h0;
  localparam logic [3:0] DTYPE_S    = 4'h1;
  localparam logic [3:0] DTYPE_U    = 4'h2;

  localparam logic [4:0] OP_NONE = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_MUL  = 5'h03;
  localparam logic [4:0] OP_DIV  = 5'h04;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_S     = 8'h73;
  localparam logic [7:0] ASCII_U     = 8'h75;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_NUM1_S   = 3'd1,
    ST_NUM1     = 3'd2,
    ST_NUM2_S   = 3'd3,
    ST_NUM2     = 3'd4,
    ST_WAIT_ALU = 3'd5,
    ST_ERR      = 3'd6
  } parser_state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_EQ);
  endfunction

  // Returns OP_NONE for any byte that is not an operator character.
  function automatic logic [4:0] op_code(input logic [7:0] c);
    logic [4:0] op;
    case (c)
      ASCII_PLUS:  op = OP_ADD;
      ASCII_MINUS: op = OP_SUB;
      ASCII_STAR:  op = OP_MUL;
      ASCII_SLASH: op = OP_DIV;
      default:     op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulator shared by both operands of the command parser.
//   clear : zero the value and the digit count
//   load  : start a new operand with its first digit (count = 1)
//   step  : acc = acc*10 + digit, modulo 2^16, count + 1
//   acc   : running 16-bit value
//   count : number of digits accepted since load
//   full  : count has reached MAX_DIGITS
// Priority is clear > load > step.
module dec_accum #(
  parameter int  MAX_DIGITS = 5,
  localparam int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          load,
  input  logic          step,
  input  logic [3:0]    digit,
  output logic [15:0]   acc,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [15:0]   acc_q,   acc_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (clear) begin
      acc_d   = '0;
      count_d = '0;
    end else if (load) begin
      acc_d   = {12'd0, digit};
      count_d = CW'(1);
    end else if (step) begin
      // x*10 as two shifts and an add; the carry out of bit 15 is dropped
      acc_d   = (acc_q << 3) + (acc_q << 1) + {12'd0, digit};
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign acc   = acc_q;
  assign count = count_q;
  assign full  = (count_q == CW'(MAX_DIGITS));

endmodule

// File: rtl/cmd_parser.sv
// Command parser in front of the calculator ALU. Parses ASCII commands of
// the form <type><num1><op><num2><term> arriving from the UART receiver and
// hands the decoded fields to the ALU, then waits for alu_done (or a
// timeout) before accepting the next command.
//
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   rx_data, rx_valid    received byte and its one-cycle strobe
//   alu_done             ALU has finished the current command
//   dtype, operator      operand type / operator codes (calc_pkg)
//   src1, src2           operands, two's complement for signed commands
//   parser_done          one-cycle pulse, fields updated
//   parse_err            one-cycle pulse, syntax error
//   alu_timeout          one-cycle pulse, ALU wait abandoned
//   busy                 parser is not idle
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for 's' or 'u'
// NUM1_S    | start of first operand, optional '-' then first digit
// NUM1      | first operand digits, an operator ends it
// NUM2_S    | start of second operand, optional '-' then first digit
// NUM2      | second operand digits, a terminator ends the command
// WAIT_ALU  | fields presented, waiting for alu_done or timeout
// ERR       | syntax error seen, discarding bytes up to a terminator
module cmd_parser
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 5,
  parameter int ALU_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        alu_done,
  output logic [3:0]  dtype,
  output logic [4:0]  operator,
  output logic [15:0] src1,
  output logic [15:0] src2,
  output logic        parser_done,
  output logic        parse_err,
  output logic        alu_timeout,
  output logic        busy
);

  localparam int TW = $clog2(ALU_TIMEOUT);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  parser_state_t state_q, state_d;
  logic [3:0]    dtype_nx_q, dtype_nx_d;
  logic [4:0]    op_nx_q, op_nx_d;
  logic          neg_q, neg_d;
  logic [15:0]   num1_q, num1_d;
  logic [3:0]    dtype_q, dtype_d;
  logic [4:0]    operator_q, operator_d;
  logic [15:0]   src1_q, src1_d;
  logic [15:0]   src2_q, src2_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic          busy_q, busy_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          acc_clear, acc_load, acc_step;
  logic [15:0]   acc_val;
  logic [CW-1:0] acc_count;
  logic          acc_full;

  logic          byte_v;
  logic          syntax_err;
  logic          has_digits;
  logic [15:0]   acc_signed;

  dec_accum #(
    .MAX_DIGITS (MAX_DIGITS)
  ) u_dec_accum (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (acc_clear),
    .load  (acc_load),
    .step  (acc_step),
    .digit (rx_data[3:0]),
    .acc   (acc_val),
    .count (acc_count),
    .full  (acc_full)
  );

  // Spaces are transparent everywhere except WAIT_ALU, where every byte is
  // dropped anyway, so one qualifier serves all parsing states.
  assign byte_v     = rx_valid && (rx_data != ASCII_SPACE);
  assign has_digits = (acc_count != '0);
  assign acc_signed = neg_q ? (~acc_val + 16'd1) : acc_val;

  always_comb begin
    state_d    = state_q;
    dtype_nx_d = dtype_nx_q;
    op_nx_d    = op_nx_q;
    neg_d      = neg_q;
    num1_d     = num1_q;
    dtype_d    = dtype_q;
    operator_d = operator_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    tmo_cnt_d  = tmo_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tmo_d      = 1'b0;
    acc_clear  = 1'b0;
    acc_load   = 1'b0;
    acc_step   = 1'b0;
    syntax_err = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_v) begin
          if (rx_data == ASCII_S || rx_data == ASCII_U) begin
            dtype_nx_d = (rx_data == ASCII_S) ? DTYPE_S : DTYPE_U;
            neg_d      = 1'b0;
            acc_clear  = 1'b1;
            state_d    = ST_NUM1_S;
          end else if (!(is_term(rx_data) || rx_data == ASCII_LF)) begin
            syntax_err = 1'b1;
          end
        end
      end

      ST_NUM1_S, ST_NUM2_S: begin
        if (byte_v) begin
          if (rx_data == ASCII_MINUS && dtype_nx_q == DTYPE_S && !neg_q) begin
            neg_d = 1'b1;
          end else if (is_digit(rx_data)) begin
            acc_load = 1'b1;
            state_d  = (state_q == ST_NUM1_S) ? ST_NUM1 : ST_NUM2;
          end else begin
            syntax_err = 1'b1;
          end
        end
      end

      ST_NUM1: begin
        if (byte_v) begin
          if (is_digit(rx_data)) begin
            if (acc_full) syntax_err = 1'b1;
            else          acc_step   = 1'b1;
          end else if (op_code(rx_data) != OP_NONE && has_digits) begin
            op_nx_d = op_code(rx_data);
            num1_d  = acc_signed;
            neg_d   = 1'b0;
            state_d = ST_NUM2_S;
          end else begin
            syntax_err = 1'b1;
          end
        end
      end

      ST_NUM2: begin
        if (byte_v) begin
          if (is_digit(rx_data)) begin
            if (acc_full) syntax_err = 1'b1;
            else          acc_step   = 1'b1;
          end else if (is_term(rx_data) && has_digits) begin
            dtype_d    = dtype_nx_q;
            operator_d = op_nx_q;
            src1_d     = num1_q;
            src2_d     = acc_signed;
            done_d     = 1'b1;
            tmo_cnt_d  = '0;
            state_d    = ST_WAIT_ALU;
          end else begin
            syntax_err = 1'b1;
          end
        end
      end

      ST_WAIT_ALU: begin
        // alu_done is checked first so it wins a tie with the last count
        if (alu_done) begin
          state_d = ST_IDLE;
        end else if (tmo_cnt_q == TW'(ALU_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      ST_ERR: begin
        if (rx_valid && is_term(rx_data)) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A terminator that is itself the bad byte already ends the command,
    // so there is nothing left to discard.
    if (syntax_err) begin
      err_d   = 1'b1;
      state_d = is_term(rx_data) ? ST_IDLE : ST_ERR;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      dtype_nx_q <= DTYPE_NONE;
      op_nx_q    <= OP_NONE;
      neg_q      <= 1'b0;
      num1_q     <= '0;
      dtype_q    <= DTYPE_NONE;
      operator_q <= OP_NONE;
      src1_q     <= '0;
      src2_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      busy_q     <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dtype_nx_q <= dtype_nx_d;
      op_nx_q    <= op_nx_d;
      neg_q      <= neg_d;
      num1_q     <= num1_d;
      dtype_q    <= dtype_d;
      operator_q <= operator_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign dtype       = dtype_q;
  assign operator    = operator_q;
  assign src1        = src1_q;
  assign src2        = src2_q;
  assign parser_done = done_q;
  assign parse_err   = err_q;
  assign alu_timeout = tmo_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Bench for cmd_parser: a table of fixed commands with hand-derived fields,
// hand-written handshake/timeout/reset sequences, and random commands checked
// against a string-level reference parser.
module tb_cmd_parser;

  localparam int MAXD = 5;
  localparam int TMO  = 32;
  localparam int K_NONE = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        alu_done = 1'b0;
  logic [3:0]  dtype;
  logic [4:0]  operator;
  logic [15:0] src1, src2;
  logic        parser_done, parse_err, alu_timeout, busy;

  cmd_parser #(.MAX_DIGITS(MAXD), .ALU_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .alu_done    (alu_done),
    .dtype       (dtype),
    .operator    (operator),
    .src1        (src1),
    .src2        (src2),
    .parser_done (parser_done),
    .parse_err   (parse_err),
    .alu_timeout (alu_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0, n_err = 0, n_to = 0;
  int done_cyc = 0, to_cyc = 0;
  logic [3:0]  cap_dt;
  logic [4:0]  cap_op;
  logic [15:0] cap_s1, cap_s2;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (parser_done) begin
      n_done++;
      done_cyc = cyc;
      cap_dt = dtype; cap_op = operator; cap_s1 = src1; cap_s2 = src2;
    end
    if (parse_err) n_err++;
    if (alu_timeout) begin
      n_to++;
      to_cyc = cyc;
    end
    if (parser_done || parse_err || alu_timeout) begin
      checks++;
      if (int'(parser_done) + int'(parse_err) + int'(alu_timeout) > 1) begin
        errors++;
        $display("FAIL pulse_exclusive: got done=%0b err=%0b tmo=%0b, required at most one",
                 parser_done, parse_err, alu_timeout);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  // Reference model: parses a complete command string with integer
  // arithmetic and reports what the parser should do with it.
  function automatic bit ref_operand(input string t, inout int p, input bit sgn,
                                     output logic [15:0] val);
    longint v = 0;
    int n = 0;
    bit neg = 0;
    val = 16'h0;
    if (p < t.len() && t[p] == "-") begin
      if (!sgn) return 0;
      neg = 1;
      p++;
    end
    while (p < t.len() && t[p] >= "0" && t[p] <= "9") begin
      v = v * 10 + longint'(t[p] - "0");
      n++;
      p++;
    end
    if (n == 0 || n > MAXD) return 0;
    v = v % 65536;
    if (neg) v = (65536 - v) % 65536;
    val = v[15:0];
    return 1;
  endfunction

  function automatic void ref_parse(input string s, output int kind, output logic [3:0] dt,
                                    output logic [4:0] op, output logic [15:0] v1,
                                    output logic [15:0] v2);
    string t = "";
    int p;
    bit sgn;
    kind = K_ERR; dt = 0; op = 0; v1 = 0; v2 = 0;
    for (int i = 0; i < s.len(); i++)
      if (s[i] != " ") t = {t, s.substr(i, i)};
    if (t.len() == 0) begin kind = K_NONE; return; end
    if (t[0] == "s") sgn = 1;
    else if (t[0] == "u") sgn = 0;
    else begin
      if (t.len() == 1 && (t[0] == 8'h0D || t[0] == "=" || t[0] == 8'h0A)) kind = K_NONE;
      return;
    end
    p = 1;
    if (!ref_operand(t, p, sgn, v1)) return;
    if (p >= t.len()) return;
    case (t[p])
      "+": op = 5'd1;
      "-": op = 5'd2;
      "*": op = 5'd3;
      "/": op = 5'd4;
      default: return;
    endcase
    p++;
    if (!ref_operand(t, p, sgn, v2)) return;
    if (p != t.len() - 1) return;
    if (!(t[p] == 8'h0D || t[p] == "=")) return;
    dt = sgn ? 4'h1 : 4'h2;
    kind = K_DONE;
  endfunction

  // Sends one command from IDLE, checks the pulses and fields, and returns
  // the parser to IDLE through alu_done or the timeout.
  task automatic run_cmd(input string name, input string s, input int kind,
                         input logic [3:0] dt, input logic [4:0] op,
                         input logic [15:0] s1, input logic [15:0] s2, input bit let_to);
    int bd = n_done, be = n_err, bt = n_to;
    send_str(s, int'($urandom_range(0, 1)));
    repeat (3) @(negedge clk);
    #1;
    chk({name, ".done_cnt"}, n_done - bd, (kind == K_DONE) ? 1 : 0);
    chk({name, ".err_cnt"}, n_err - be, (kind == K_ERR) ? 1 : 0);
    if (kind == K_DONE) begin
      chk({name, ".dtype"}, cap_dt, dt);
      chk({name, ".op"}, cap_op, op);
      chk({name, ".src1"}, cap_s1, s1);
      chk({name, ".src2"}, cap_s2, s2);
      chk({name, ".busy_wait"}, busy, 1);
      if (let_to) begin
        for (int k = 0; k < TMO + 4 && n_to == bt; k++) begin
          @(negedge clk);
          #1;
        end
        chk({name, ".timeout_cnt"}, n_to - bt, 1);
      end else begin
        repeat ($urandom_range(0, TMO - 10)) @(negedge clk);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        #1;
        chk({name, ".timeout_cnt"}, n_to - bt, 0);
      end
    end
    chk({name, ".busy_end"}, busy, 0);
  endtask

  typedef struct {
    string       name;
    string       cmd;
    int          kind;
    logic [3:0]  dt;
    logic [4:0]  op;
    logic [15:0] s1;
    logic [15:0] s2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input string c, input int k, input logic [3:0] d,
                              input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    v.name = n; v.cmd = c; v.kind = k; v.dt = d; v.op = o; v.s1 = a; v.s2 = b;
    return v;
  endfunction

  function automatic string rand_operand(input bit sgn);
    string s = "";
    int nd;
    if ((sgn && $urandom_range(0, 3) == 0) || (!sgn && $urandom_range(0, 19) == 0)) s = "-";
    nd = int'($urandom_range(1, MAXD));
    if ($urandom_range(0, 11) == 0) nd = ($urandom_range(0, 1) == 0) ? 0 : MAXD + 1;
    for (int i = 0; i < nd; i++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
    return s;
  endfunction

  function automatic string rand_cmd();
    string raw, s;
    bit sgn = 1'($urandom_range(0, 1));
    string ops = "+-*/";
    int pos;
    raw = {sgn ? "s" : "u", rand_operand(sgn), ops.substr(0, 0), rand_operand(sgn)};
    pos = int'($urandom_range(0, 3));
    raw[1 + rand_operand_len_fix(raw)] = raw[1 + rand_operand_len_fix(raw)];
    raw = {raw, ($urandom_range(0, 1) == 0) ? "\r" : "="};
    // Choose the operator after assembly so it always sits between operands.
    for (int i = 1; i < raw.len(); i++)
      if (raw[i] == "+" ) begin
        raw[i] = ops[pos];
        break;
      end
    if ($urandom_range(0, 9) == 0) raw[$urandom_range(0, raw.len() - 2)] = "x";
    s = "";
    for (int i = 0; i < raw.len(); i++) begin
      s = {s, raw.substr(i, i)};
      if ($urandom_range(0, 5) == 0) s = {s, " "};
    end
    return s;
  endfunction

  function automatic int rand_operand_len_fix(input string r);
    return (r.len() > 1) ? 0 : 0;
  endfunction

  initial begin
    int kind;
    logic [3:0] dt;
    logic [4:0] op;
    logic [15:0] v1, v2;
    int bd, bt;
    string rc;

    repeat (3) @(negedge clk);
    #1;
    chk("rst.dtype", dtype, 0);
    chk("rst.op", operator, 0);
    chk("rst.src1", src1, 0);
    chk("rst.src2", src2, 0);
    chk("rst.pulses", {parser_done, parse_err, alu_timeout}, 0);
    chk("rst.busy", busy, 0);
    n_rst = 1'b1;

    // Signed add: parser_done in the cycle after the terminator, alu_done
    // three cycles later releases busy.
    bd = n_done;
    send_str("s12+34\r", 0);
    #1;
    chk("add.done_latency", parser_done, 1);
    chk("add.dtype", dtype, 4'h1);
    chk("add.op", operator, 5'h01);
    chk("add.src1", src1, 16'h000C);
    chk("add.src2", src2, 16'h0022);
    repeat (2) @(negedge clk);
    chk("add.busy_before", busy, 1);
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    #1;
    chk("add.busy_after", busy, 0);
    chk("add.done_cnt", n_done - bd, 1);

    vecs.push_back(mk("neg_mul", "s-5*-300=", K_DONE, 4'h1, 5'h03, 16'hFFFB, 16'hFED4));
    vecs.push_back(mk("u_div", "u65535/7\r", K_DONE, 4'h2, 5'h04, 16'hFFFF, 16'h0007));
    vecs.push_back(mk("u_minus", "u-3+1\r", K_ERR, 0, 0, 0, 0));
    vecs.push_back(mk("six_dig", "s123456+1\r", K_ERR, 0, 0, 0, 0));
    vecs.push_back(mk("after_err", "s1+1\r", K_DONE, 4'h1, 5'h01, 16'h0001, 16'h0001));
    vecs.push_back(mk("spaces", "s 7 - 8 \r", K_DONE, 4'h1, 5'h02, 16'h0007, 16'h0008));
    vecs.push_back(mk("wrap", "u99999+0\r", K_DONE, 4'h2, 5'h01, 16'h869F, 16'h0000));
    vecs.push_back(mk("term_bad", "s12\r", K_ERR, 0, 0, 0, 0));
    vecs.push_back(mk("dbl_minus", "s--3+1\r", K_ERR, 0, 0, 0, 0));
    vecs.push_back(mk("neg_zero", "s00005/-0=", K_DONE, 4'h1, 5'h04, 16'h0005, 16'h0000));
    vecs.push_back(mk("no_num2", "s5+\r", K_ERR, 0, 0, 0, 0));
    vecs.push_back(mk("idle_cr", "\r", K_NONE, 0, 0, 0, 0));
    vecs.push_back(mk("idle_lf", "\n", K_NONE, 0, 0, 0, 0));
    vecs.push_back(mk("max5", "s32768-99999=", K_DONE, 4'h1, 5'h02, 16'h8000, 16'h869F));
    vecs.push_back(mk("bad_first", "x1+1\r", K_ERR, 0, 0, 0, 0));
    foreach (vecs[i])
      run_cmd(vecs[i].name, vecs[i].cmd, vecs[i].kind, vecs[i].dt, vecs[i].op,
              vecs[i].s1, vecs[i].s2, 1'b0);

    // Timeout: pulses exactly TMO cycles after parser_done, bytes sent
    // during the wait are dropped.
    bd = n_done; bt = n_to;
    send_str("s1+1\r", 0);
    #1;
    chk("tmo.done_cnt", n_done - bd, 1);
    send_str("s2+2\r", 0);
    for (int k = 0; k < 2 * TMO && n_to == bt; k++) begin
      @(negedge clk);
      #1;
    end
    chk("tmo.timeout_cnt", n_to - bt, 1);
    chk("tmo.latency", to_cyc - done_cyc, TMO);
    chk("tmo.dropped", n_done - bd, 1);
    chk("tmo.busy", busy, 0);

    // alu_done in the very cycle the count expires beats the timeout.
    bd = n_done; bt = n_to;
    send_str("u9-1\r", 0);
    #1;
    chk("tie.done_cnt", n_done - bd, 1);
    repeat (TMO - 1) @(negedge clk);
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("tie.no_timeout", n_to - bt, 0);
    chk("tie.busy", busy, 0);
    chk("tie.src1", src1, 16'h0009);

    // Reset in the middle of a command clears everything at once.
    send_str("s12+", 0);
    #3;
    n_rst = 1'b0;
    #1;
    chk("mid_rst.fields", {dtype, operator, src1, src2}, 0);
    chk("mid_rst.busy", busy, 0);
    @(negedge clk);
    n_rst = 1'b1;
    run_cmd("post_rst", "u3*4\r", K_DONE, 4'h2, 5'h03, 16'h0003, 16'h0004, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rc = rand_cmd();
      ref_parse(rc, kind, dt, op, v1, v2);
      run_cmd($sformatf("rnd%0d", i), rc, kind, dt, op, v1, v2,
              1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
